// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a length-prefixed, checksummed frame and
// writes the payload into instruction memory while holding the CPU pipeline.
module imem_loader #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_mem_wEn,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_bytes_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

  logic [1:0]  r_rst_sync;
  logic [2:0]  r_state;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [7:0]  r_sum;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [7:0]  r_wdata;

  logic        w_xfer;
  logic [15:0] w_len_full;
  logic [15:0] w_cnt_next;

  assign o_in_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                      (r_state == S_DATA)   || (r_state == S_CHK);
  assign w_xfer     = o_in_ready & i_in_valid;
  assign w_len_full = {i_in_data, r_len[7:0]};
  assign w_cnt_next = r_cnt + 16'd1;

  // Reset asserts asynchronously but is released only after two clock edges.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
      r_cnt   <= 16'd0;
      r_sum   <= 8'd0;
      r_wen   <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 8'd0;
    end else if (!r_rst_sync[1]) begin
      r_wen <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state <= S_LEN_LO;
            r_len   <= 16'd0;
            r_cnt   <= 16'd0;
            r_sum   <= 8'd0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= i_in_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len <= w_len_full;
            if (w_len_full == 16'd0)                      r_state <= S_CHK;
            else if ({16'd0, w_len_full} > MEM_BYTES_W)   r_state <= S_ERR;
            else                                          r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_wen   <= 1'b1;
            r_addr  <= BASE_ADDR + {48'd0, r_cnt};
            r_wdata <= i_in_data;
            r_sum   <= r_sum + i_in_data;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == r_len) r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_xfer) r_state <= (i_in_data == r_sum) ? S_DONE : S_ERR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_wEn      = r_wen;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;
  assign o_bytes_loaded = r_cnt;
  assign o_done         = (r_state == S_DONE);
  assign o_err          = (r_state == S_ERR);
  assign o_cpu_hold     = (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_imem_loader;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, mem_wEn, cpu_hold, done, err;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] bytes_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  logic [7:0]  q_tx[$];
  logic [7:0]  q_pay[$];
  logic [63:0] mon_addr[$];
  logic [7:0]  mon_data[$];
  int unsigned mon_cyc[$];

  imem_loader #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(64'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_mem_wEn(mem_wEn),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_cpu_hold(cpu_hold),
    .o_done(done), .o_err(err), .o_bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mem_wEn === 1'b1) begin
      mon_addr.push_back(mem_addr);
      mon_data.push_back(mem_wdata);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic mon_clear();
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit ok;
    ok = 1'b0;
    if (thr) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); @(negedge clk);
      end
    end
    in_valid = 1'b1; in_data = b;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0 exp 1 for byte %02h", b);
    end
  endtask

  task automatic send_stream(input bit thr);
    for (int i = 0; i < q_tx.size(); i++) send_byte(q_tx[i], thr);
  endtask

  // Reference framing: oversize frames stop after the length bytes.
  task automatic build_frame(input int len, input bit good_chk);
    logic [7:0] sum;
    sum = 8'd0;
    q_pay.delete(); q_tx.delete();
    q_tx.push_back(len[7:0]);
    q_tx.push_back(len[15:8]);
    if (len > MEM_BYTES) return;
    for (int i = 0; i < len; i++) begin
      q_pay.push_back(8'($urandom));
      sum = 8'((int'(sum) + int'(q_pay[i])) % 256);
      q_tx.push_back(q_pay[i]);
    end
    q_tx.push_back(good_chk ? sum : 8'(sum + 8'($urandom_range(1, 255))));
  endtask

  task automatic test_reset();
    #13;
    n_tests++;
    if ({in_ready, mem_wEn, cpu_hold, done, err} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 00100", {in_ready, mem_wEn, cpu_hold, done, err});
    end
    n_tests++;
    if (mem_addr !== 64'd0 || mem_wdata !== 8'd0 || bytes_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: got addr %0h data %0h cnt %0d exp 0", mem_addr, mem_wdata, bytes_loaded);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sync_first_edge: in_ready got %b exp 0", in_ready);
    end
    for (int n = 0; n < 6 && in_ready !== 1'b1; n++) @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_start: in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    mon_clear();
    pulse_start();
    n_tests++;
    if (cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL nominal_hold_during: got %b exp 1", cpu_hold);
    end
    q_tx = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'h2C};
    q_pay = '{8'h30, 8'hF2, 8'h0A};
    send_stream(1'b0);
    n_tests++;
    if (mon_addr.size() != 3) begin
      n_fail++; $display("FAIL nominal_wr_count: got %0d exp 3", mon_addr.size());
    end
    for (int i = 0; i < 3 && i < mon_addr.size(); i++) begin
      n_tests++;
      if (mon_addr[i] !== 64'(i) || mon_data[i] !== q_pay[i] || mon_cyc[i] != mon_cyc[0] + i) begin
        n_fail++;
        $display("FAIL nominal_write%0d: got %02h@%0h cyc+%0d exp %02h@%0h cyc+%0d",
                 i, mon_data[i], mon_addr[i], mon_cyc[i] - mon_cyc[0], q_pay[i], i, i);
      end
    end
    n_tests++;
    if ({done, err, cpu_hold, in_ready} !== 4'b1000 || bytes_loaded !== 16'd3) begin
      n_fail++;
      $display("FAIL nominal_done: got d/e/h/r %b cnt %0d exp 1000 cnt 3",
               {done, err, cpu_hold, in_ready}, bytes_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    mon_clear();
    pulse_start();
    q_tx = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'h2D};
    send_stream(1'b0);
    n_tests++;
    if (mon_addr.size() != 3) begin
      n_fail++; $display("FAIL badchk_wr_count: got %0d exp 3", mon_addr.size());
    end
    n_tests++;
    if ({done, err, cpu_hold} !== 3'b011 || bytes_loaded !== 16'd3) begin
      n_fail++;
      $display("FAIL badchk_err: got d/e/h %b cnt %0d exp 011 cnt 3", {done, err, cpu_hold}, bytes_loaded);
    end
  endtask

  task automatic test_oversize();
    mon_clear();
    pulse_start();
    q_tx = '{8'h01, 8'h04};
    send_stream(1'b0);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if ({done, err, cpu_hold, in_ready} !== 4'b0110 || mon_addr.size() != 0) begin
      n_fail++;
      $display("FAIL oversize: got d/e/h/r %b writes %0d exp 0110 writes 0",
               {done, err, cpu_hold, in_ready}, mon_addr.size());
    end
  endtask

  task automatic test_zero_len();
    mon_clear();
    pulse_start();
    q_tx = '{8'h00, 8'h00, 8'h00};
    send_stream(1'b1);
    n_tests++;
    if ({done, err, cpu_hold} !== 3'b100 || mon_addr.size() != 0 || bytes_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_len_ok: got d/e/h %b writes %0d exp 100 writes 0", {done, err, cpu_hold}, mon_addr.size());
    end
    pulse_start();
    q_tx = '{8'h00, 8'h00, 8'h01};
    send_stream(1'b0);
    n_tests++;
    if ({done, err, cpu_hold} !== 3'b011 || mon_addr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len_bad: got d/e/h %b writes %0d exp 011 writes 0", {done, err, cpu_hold}, mon_addr.size());
    end
  endtask

  task automatic test_throttle_reset();
    mon_clear();
    pulse_start();
    build_frame(16, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(q_tx[i], 1'b1);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, mem_wEn, cpu_hold, done, err} !== 5'b00100 || mem_addr !== 64'd0 ||
        mem_wdata !== 8'd0 || bytes_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL throttle_reset_vals: got r/w/h/d/e %b addr %0h data %0h cnt %0d exp 00100 0 0 0",
               {in_ready, mem_wEn, cpu_hold, done, err}, mem_addr, mem_wdata, bytes_loaded);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mon_addr.size() != 8) begin
      n_fail++; $display("FAIL throttle_wr_count: got %0d exp 8", mon_addr.size());
    end
    for (int i = 0; i < 8 && i < mon_addr.size(); i++) begin
      n_tests++;
      if (mon_addr[i] !== 64'(i) || mon_data[i] !== q_pay[i]) begin
        n_fail++;
        $display("FAIL throttle_write%0d: got %02h@%0h exp %02h@%0h", i, mon_data[i], mon_addr[i], q_pay[i], i);
      end
    end
    mon_clear();
    pulse_start();
    build_frame(16, 1'b1);
    send_stream(1'b1);
    n_tests++;
    if (done !== 1'b1 || mon_addr.size() != 16 || bytes_loaded !== 16'd16) begin
      n_fail++;
      $display("FAIL throttle_reload: got done %b writes %0d cnt %0d exp 1 16 16", done, mon_addr.size(), bytes_loaded);
    end
  endtask

  task automatic test_wrap_restart();
    mon_clear();
    pulse_start();
    q_tx = '{8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
    send_stream(1'b0);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b0 || mon_addr.size() != 3) begin
      n_fail++; $display("FAIL wrap_done: got done %b err %b writes %0d exp 1 0 3", done, err, mon_addr.size());
    end
    pulse_start();
    n_tests++;
    if ({done, cpu_hold, in_ready} !== 3'b011 || bytes_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_restart: got d/h/r %b cnt %0d exp 011 cnt 0", {done, cpu_hold, in_ready}, bytes_loaded);
    end
  endtask

  task automatic test_start_ignored();
    mon_clear();
    q_tx = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    start = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(q_tx[i], 1'b0);
    start = 1'b0;
    send_byte(q_tx[4], 1'b0);
    n_tests++;
    if (done !== 1'b1 || bytes_loaded !== 16'd2 || mon_addr.size() != 2) begin
      n_fail++;
      $display("FAIL start_ignored: got done %b cnt %0d writes %0d exp 1 2 2", done, bytes_loaded, mon_addr.size());
    end
  endtask

  task automatic test_idle_start_valid();
    apply_reset();
    mon_clear();
    in_valid = 1'b1; in_data = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    q_tx = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'h65};
    send_stream(1'b0);
    n_tests++;
    if (done !== 1'b1 || bytes_loaded !== 16'd2 || mon_addr.size() != 2) begin
      n_fail++;
      $display("FAIL idle_start_valid: got done %b cnt %0d writes %0d exp 1 2 2", done, bytes_loaded, mon_addr.size());
    end
  endtask

  task automatic test_boundary_len();
    mon_clear();
    pulse_start();
    build_frame(MEM_BYTES, 1'b1);
    send_stream(1'b0);
    n_tests++;
    if (done !== 1'b1 || bytes_loaded !== 16'(MEM_BYTES) || mon_addr.size() != MEM_BYTES) begin
      n_fail++;
      $display("FAIL max_len: got done %b cnt %0d writes %0d exp 1 %0d", done, bytes_loaded, mon_addr.size(), MEM_BYTES);
    end
    if (mon_addr.size() == MEM_BYTES) begin
      n_tests++;
      if (mon_addr[MEM_BYTES-1] !== 64'(MEM_BYTES - 1) || mon_data[MEM_BYTES-1] !== q_pay[MEM_BYTES-1]) begin
        n_fail++;
        $display("FAIL max_len_last: got %02h@%0h exp %02h@%0h", mon_data[MEM_BYTES-1],
                 mon_addr[MEM_BYTES-1], q_pay[MEM_BYTES-1], MEM_BYTES - 1);
      end
    end
    mon_clear();
    pulse_start();
    build_frame(MEM_BYTES + 1, 1'b1);
    send_stream(1'b0);
    n_tests++;
    if (err !== 1'b1 || mon_addr.size() != 0) begin
      n_fail++; $display("FAIL max_len_plus1: got err %b writes %0d exp 1 0", err, mon_addr.size());
    end
  endtask

  task automatic test_random();
    int  len;
    bit  good, thr, exp_done;
    int  exp_nw;
    for (int it = 0; it < 30; it++) begin
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MEM_BYTES + 1, 65535))
                                         : int'($urandom_range(0, 24));
      good = ($urandom_range(0, 3) != 0);
      thr  = 1'($urandom_range(0, 1));
      exp_nw   = (len > MEM_BYTES) ? 0 : len;
      exp_done = (len <= MEM_BYTES) && good;
      mon_clear();
      pulse_start();
      build_frame(len, good);
      send_stream(thr);
      @(negedge clk);
      n_tests++;
      if (done !== exp_done || err !== !exp_done || cpu_hold !== !exp_done ||
          bytes_loaded !== 16'(exp_nw) || mon_addr.size() != exp_nw) begin
        n_fail++;
        $display("FAIL rand%0d len %0d: got d/e/h %b%b%b cnt %0d writes %0d exp %b%b%b cnt %0d",
                 it, len, done, err, cpu_hold, bytes_loaded, mon_addr.size(),
                 exp_done, !exp_done, !exp_done, exp_nw);
      end
      for (int i = 0; i < exp_nw && i < mon_addr.size(); i++) begin
        n_tests++;
        if (mon_addr[i] !== 64'(i) || mon_data[i] !== q_pay[i]) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %02h@%0h exp %02h@%0h", it, i, mon_data[i], mon_addr[i], q_pay[i], i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize();
    test_zero_len();
    test_throttle_reset();
    test_wrap_restart();
    test_start_ignored();
    test_idle_start_valid();
    test_boundary_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
